// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared definitions for the HD44780-style character-LCD responder:
//            opcode class masks, FSM state encoding, DDRAM constants and the
//            cursor-address stepping rule.
// Ports    : none (package)
// Config   : none
// Revision : 1.0  initial release
// ============================================================================
package lcd_pkg;

   // Opcode class masks; an instruction belongs to the class of its highest
   // set bit.
   localparam logic [7:0] CLR   = 8'h01;
   localparam logic [7:0] HOME  = 8'h02;
   localparam logic [7:0] ENTRY = 8'h04;
   localparam logic [7:0] DISP  = 8'h08;
   localparam logic [7:0] SHIFT = 8'h10;
   localparam logic [7:0] FUNC  = 8'h20;
   localparam logic [7:0] CGRAM = 8'h40;
   localparam logic [7:0] DDRAM = 8'h80;

   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [7:0] SPACE      = 8'h20;

   localparam logic [6:0] LINE0_LAST = 7'h0F;
   localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'h0F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SWEEP = 2'd2,
      ST_WAIT  = 2'd3
   } lcd_state_t;

   // True when mask is the highest set bit of cmd.
   function automatic logic op_match(input logic [7:0] cmd, input logic [7:0] mask);
      logic [7:0] above;
      above = ~((mask << 1) - 8'd1);
      return ((cmd & mask) != 8'h00) && ((cmd & above) == 8'h00);
   endfunction

   // Move the cursor one cell, wrapping line 0 end <-> line 1 start.
   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
      logic [6:0] nxt;
      if (inc) begin
         if (a == LINE0_LAST)      nxt = LINE1_BASE;
         else if (a == LINE1_LAST) nxt = 7'h00;
         else                      nxt = a + 7'd1;
      end else begin
         if (a == 7'h00)           nxt = LINE1_LAST;
         else if (a == LINE1_BASE) nxt = LINE0_LAST;
         else                      nxt = a - 7'd1;
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ddram
// Purpose  : 32x8 display data RAM, one write port, one combinational bus
//            read port and one registered side read port.
// Ports    : clk, rst (async, active-low)
//            we, waddr[4:0], wdata[7:0]   write port
//            bus_idx[4:0] -> bus_data[7:0] combinational read
//            rd_idx[4:0]  -> rd_char[7:0]  registered read, 1-cycle latency
// Config   : none
// Revision : 1.0  initial release
// ============================================================================
module lcd_ddram (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [4:0] bus_idx,
   output logic [7:0] bus_data,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char
);

   logic [7:0] r_mem [32];

   // Storage has no reset; the power-on clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign bus_data = r_mem[bus_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_char <= 8'h00;
      else      rd_char <= r_mem[rd_idx];
   end

endmodule
`default_nettype wire

// File: rtl/lcd_char_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_responder
// Purpose  : Responder end of an HD44780-style 8-bit character-LCD bus.
//            Decodes E-strobed instruction/data writes, keeps a 2x16 DDRAM,
//            cursor address and busy flag, and exposes a side read port.
// Ports    : clk, rst (async, active-low)
//            e, rs, rw, db_in[7:0]          bus inputs
//            db_out[7:0], db_oe             bus read data / drive enable
//            busy, display_on, cursor_on, blink_on, overrun
//            rd_idx[4:0] -> rd_char[7:0]    side read port
// Config   : LCD_READ_EN - when defined, status and data reads are answered;
//            otherwise db_oe/db_out are tied low and rw=1 strobes ignored.
// Revision : 1.0  initial release
// ============================================================================
module lcd_char_responder
   import lcd_pkg::*;
#(
   parameter int BUSY_CYCLES  = 40,
   parameter int CLEAR_CYCLES = 1640
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       e,
   input  logic       rs,
   input  logic       rw,
   input  logic [7:0] db_in,
   output logic [7:0] db_out,
   output logic       db_oe,
   output logic       busy,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char,
   output logic       overrun
);

   localparam int c_MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW           = $clog2(c_MAX_CYCLES);
   // Counter loads are one short: the load cycle itself is the first busy cycle.
   localparam logic [CW-1:0] c_BUSY_LOAD = CW'(BUSY_CYCLES - 1);
   localparam logic [CW-1:0] c_CLR_LOAD  = CW'(CLEAR_CYCLES - 1);
   localparam logic [4:0]    c_LAST_CELL = 5'd31;

   lcd_state_t     r_state;
   lcd_state_t     w_state_nxt;

   logic           r_e_q;
   logic [7:0]     r_cmd;
   logic           r_rs;
   logic [6:0]     r_addr;
   logic           r_incr;
   logic           r_cg_mode;
   logic           r_display_on;
   logic           r_cursor_on;
   logic           r_blink_on;
   logic           r_eight_bit;
   logic           r_two_line;
   logic           r_busy;
   logic [CW-1:0]  r_cnt;
   logic [4:0]     r_sweep_idx;
   logic           r_overrun;

   logic           w_fall;
   logic           w_wr_fall;
   logic           w_accept;
   logic [4:0]     w_addr_idx;
   logic           w_mem_we;
   logic [4:0]     w_mem_waddr;
   logic [7:0]     w_mem_wdata;
   logic [7:0]     w_bus_rdata;
   logic           w_op_clr, w_op_home, w_op_entry, w_op_disp;
   logic           w_op_shift, w_op_func, w_op_cgram, w_op_ddram;

   assign w_fall     = r_e_q & ~e;
   assign w_wr_fall  = w_fall & ~rw;
   // busy is the registered flag, so a strobe landing on the cycle busy
   // drops still sees it set and is rejected.
   assign w_accept   = w_wr_fall & ~r_busy & (r_state == ST_IDLE);
   assign w_addr_idx = {r_addr[6], r_addr[3:0]};

   assign w_op_clr   = op_match(r_cmd, CLR);
   assign w_op_home  = op_match(r_cmd, HOME);
   assign w_op_entry = op_match(r_cmd, ENTRY);
   assign w_op_disp  = op_match(r_cmd, DISP);
   assign w_op_shift = op_match(r_cmd, SHIFT);
   assign w_op_func  = op_match(r_cmd, FUNC);
   assign w_op_cgram = op_match(r_cmd, CGRAM);
   assign w_op_ddram = op_match(r_cmd, DDRAM);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_SWEEP;   // power-on clear
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_EXEC;
         ST_EXEC:  w_state_nxt = (!r_rs && w_op_clr) ? ST_SWEEP : ST_WAIT;
         // With the minimum clear duration the count is exhausted on the
         // last cell, so there is nothing left to wait for.
         ST_SWEEP: if (r_sweep_idx == c_LAST_CELL)
                      w_state_nxt = (r_cnt == '0) ? ST_IDLE : ST_WAIT;
         ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_waddr = w_addr_idx;
      w_mem_wdata = r_cmd;
      case (r_state)
         ST_EXEC:  w_mem_we = r_rs & ~r_cg_mode;
         ST_SWEEP: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_sweep_idx;
            w_mem_wdata = SPACE;
         end
         default:  ;
      endcase
   end

   // ----------------------------------------------------------- datapath
`ifdef LCD_READ_EN
   logic w_rd_step;
   assign w_rd_step = w_fall & rw & rs & ~r_busy & (r_state == ST_IDLE);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_e_q        <= 1'b0;
         r_cmd        <= 8'h00;
         r_rs         <= 1'b0;
         r_addr       <= 7'h00;
         r_incr       <= 1'b1;
         r_cg_mode    <= 1'b0;
         r_display_on <= 1'b0;
         r_cursor_on  <= 1'b0;
         r_blink_on   <= 1'b0;
         r_eight_bit  <= 1'b0;
         r_two_line   <= 1'b0;
         r_busy       <= 1'b1;
         r_cnt        <= c_CLR_LOAD;
         r_sweep_idx  <= 5'd0;
         r_overrun    <= 1'b0;
      end else begin
         r_e_q     <= e;
         r_overrun <= w_wr_fall & r_busy;
         if (w_accept) begin
            r_cmd <= db_in;
            r_rs  <= rs;
         end
         case (r_state)
            ST_IDLE: begin
`ifdef LCD_READ_EN
               if (w_rd_step) r_addr <= addr_step(r_addr, r_incr);
`endif
            end
            ST_EXEC: begin
               r_busy <= 1'b1;
               r_cnt  <= c_BUSY_LOAD;
               if (r_rs) begin
                  if (!r_cg_mode) r_addr <= addr_step(r_addr, r_incr);
               end else if (w_op_clr) begin
                  r_addr      <= 7'h00;
                  r_incr      <= 1'b1;
                  r_cnt       <= c_CLR_LOAD;
                  r_sweep_idx <= 5'd0;
               end else if (w_op_home) begin
                  r_addr <= 7'h00;
                  r_cnt  <= c_CLR_LOAD;
               end else if (w_op_entry) begin
                  r_incr <= r_cmd[1];
               end else if (w_op_disp) begin
                  r_display_on <= r_cmd[2];
                  r_cursor_on  <= r_cmd[1];
                  r_blink_on   <= r_cmd[0];
               end else if (w_op_shift) begin
                  if (!r_cmd[3]) r_addr <= addr_step(r_addr, r_cmd[2]);
               end else if (w_op_func) begin
                  r_eight_bit <= r_cmd[4];
                  r_two_line  <= r_cmd[3];
               end else if (w_op_cgram) begin
                  r_cg_mode <= 1'b1;
               end else if (w_op_ddram) begin
                  r_addr    <= {r_cmd[6], 2'b00, r_cmd[3:0]};
                  r_cg_mode <= 1'b0;
               end
            end
            ST_SWEEP: begin
               r_sweep_idx <= r_sweep_idx + 5'd1;
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               if (r_sweep_idx == c_LAST_CELL && r_cnt == '0) r_busy <= 1'b0;
            end
            ST_WAIT: begin
               if (r_cnt == '0) r_busy <= 1'b0;
               else             r_cnt  <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------- bus reads
`ifdef LCD_READ_EN
   logic       r_db_oe;
   logic [7:0] r_db_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_db_oe  <= 1'b0;
         r_db_out <= 8'h00;
      end else begin
         r_db_oe  <= e & rw;
         r_db_out <= (e & rw) ? (rs ? w_bus_rdata : {r_busy, r_addr}) : 8'h00;
      end
   end

   assign db_oe  = r_db_oe;
   assign db_out = r_db_out;

   // Function-set flags are held for completeness only.
   logic w_unused;
   assign w_unused = ^{r_eight_bit, r_two_line};
`else
   assign db_oe  = 1'b0;
   assign db_out = 8'h00;

   logic w_unused;
   assign w_unused = ^{r_eight_bit, r_two_line, r_addr[5:4], w_bus_rdata};
`endif

   lcd_ddram u_ddram (
      .clk      (clk),
      .rst      (rst),
      .we       (w_mem_we),
      .waddr    (w_mem_waddr),
      .wdata    (w_mem_wdata),
      .bus_idx  (w_addr_idx),
      .bus_data (w_bus_rdata),
      .rd_idx   (rd_idx),
      .rd_char  (rd_char)
   );

   assign busy       = r_busy;
   assign display_on = r_display_on;
   assign cursor_on  = r_cursor_on;
   assign blink_on   = r_blink_on;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_char_responder
// Purpose  : Directed self-checking bench for lcd_char_responder.
// Ports    : none
// Config   : LCD_READ_EN selects the read-path checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_char_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       e = 1'b0;
   logic       rs = 1'b0;
   logic       rw = 1'b0;
   logic [7:0] db_in = 8'h00;
   logic [4:0] rd_idx = 5'd0;
   logic [7:0] db_out;
   logic       db_oe;
   logic       busy;
   logic       display_on;
   logic       cursor_on;
   logic       blink_on;
   logic [7:0] rd_char;
   logic       overrun;

   int n_cmp = 0;
   int n_err = 0;
   int last_lat = 0;
   int ovr_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

   lcd_char_responder #(.BUSY_CYCLES(40), .CLEAR_CYCLES(1640)) dut (
      .clk        (clk),
      .rst        (rst),
      .e          (e),
      .rs         (rs),
      .rw         (rw),
      .db_in      (db_in),
      .db_out     (db_out),
      .db_oe      (db_oe),
      .busy       (busy),
      .display_on (display_on),
      .cursor_on  (cursor_on),
      .blink_on   (blink_on),
      .rd_idx     (rd_idx),
      .rd_char    (rd_char),
      .overrun    (overrun)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One write strobe; returns how many sampled cycles busy stayed high.
   task automatic do_wr(input logic rs_v, input logic [7:0] d, output int len);
      int lat;
      @(negedge clk); rs = rs_v; rw = 1'b0; db_in = d; e = 1'b1;
      @(negedge clk); e = 1'b0;
      lat = 0;
      len = 0;
      do begin @(negedge clk); lat++; end while (!busy && lat < 4);
      last_lat = lat;
      while (busy && len < 5000) begin len++; @(negedge clk); end
   endtask

   task automatic wr(input logic rs_v, input logic [7:0] d);
      int len;
      do_wr(rs_v, d, len);
   endtask

   task automatic wr_str(input string s);
      for (int i = 0; i < s.len(); i++) wr(1'b1, s[i]);
   endtask

   task automatic peek(input logic [4:0] i, output logic [7:0] v);
      @(negedge clk); rd_idx = i;
      @(negedge clk); v = rd_char;
   endtask

   task automatic do_rd(input logic rs_v, output logic [7:0] v, output logic oe);
      @(negedge clk); rs = rs_v; rw = 1'b1; e = 1'b1;
      @(negedge clk); v = db_out; oe = db_oe; e = 1'b0;
      @(negedge clk);
      @(negedge clk); rw = 1'b0;
   endtask

   task automatic por_len(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (busy && n < 3000);
   endtask

   task automatic count_non_space(output int bad);
      logic [7:0] v;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         peek(5'(i), v);
         if (v != 8'h20) bad++;
      end
   endtask

   initial begin
      int          len;
      int          bad;
      int          base;
      logic [7:0]  v, v2;
      logic        oe;
      logic [63:0] txt;

      // ---- reset
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_flags", 64'({db_oe, overrun, display_on, cursor_on, blink_on}), 64'd0);
      chk("rst_data", 64'({db_out, rd_char}), 64'd0);

      rst = 1'b1;
      por_len(len);
      chk("por_len", 64'(len), 64'd1640);
      count_non_space(bad);
      chk("por_fill", 64'(bad), 64'd0);

      // ---- init sequence (a stray char first so the clear has work to do)
      wr(1'b1, 8'h5A);
      wr(1'b0, 8'h38);
      wr(1'b0, 8'h06);
      wr(1'b0, 8'h0C);
      do_wr(1'b0, 8'h01, len);
      chk("clr_busy_len", 64'(len), 64'd1640);
      chk("busy_rise_lat", 64'(last_lat), 64'd2);
      wr(1'b0, 8'h80);
      chk("disp_init", 64'({display_on, cursor_on, blink_on}), 64'b100);
      count_non_space(bad);
      chk("clr_fill", 64'(bad), 64'd0);

      // ---- text on both lines
      do_wr(1'b1, 8'h50, len);
      chk("data_busy_len", 64'(len), 64'd40);
      wr_str("ush Cen");
      wr(1'b0, 8'hC0);
      wr_str("ter");
      txt = '0;
      for (int i = 0; i < 8; i++) begin peek(5'(i), v); txt = {txt[55:0], v}; end
      chk("line0_text", txt, 64'h5075_7368_2043_656E);
      txt = '0;
      for (int i = 16; i < 19; i++) begin peek(5'(i), v); txt = {txt[55:0], v}; end
      chk("line1_text", txt, 64'h74_6572);

      // ---- address wrap, increment 0x4F -> 0x00
      wr(1'b0, 8'hCF);
      wr(1'b1, 8'h41);
      wr(1'b1, 8'h42);
      peek(5'd31, v); peek(5'd0, v2);
      chk("wrap_inc", 64'({v, v2}), 64'h4142);

      // ---- address wrap, decrement 0x40 -> 0x0F
      wr(1'b0, 8'h04);
      wr(1'b0, 8'hC0);
      wr(1'b1, 8'h43);
      wr(1'b1, 8'h44);
      peek(5'd16, v); peek(5'd15, v2);
      chk("wrap_dec", 64'({v, v2}), 64'h4344);
      wr(1'b0, 8'h06);

      // ---- cursor shift: right, left, left past 0x00 -> 0x4F
      wr(1'b0, 8'h80);
      wr(1'b0, 8'h14);
      wr(1'b0, 8'h10);
      wr(1'b0, 8'h10);
      wr(1'b1, 8'h51);
      peek(5'd31, v);
      chk("shift_wrap", 64'(v), 64'h51);

      // ---- display control
      wr(1'b0, 8'h0F);
      chk("disp_111", 64'({display_on, cursor_on, blink_on}), 64'b111);
      wr(1'b0, 8'h0D);
      chk("disp_101", 64'({display_on, cursor_on, blink_on}), 64'b101);

      // ---- CGRAM mode discards data, DDRAM set leaves it
      wr(1'b0, 8'h83);
      wr(1'b0, 8'h40);
      wr(1'b1, 8'h57);
      peek(5'd3, v);
      chk("cgram_discard", 64'(v), 64'h68);
      wr(1'b0, 8'h83);
      wr(1'b1, 8'h4B);
      peek(5'd3, v);
      chk("cg_exit", 64'(v), 64'h4B);

      // ---- return home
      do_wr(1'b0, 8'h02, len);
      chk("home_len", 64'(len), 64'd1640);
      wr(1'b1, 8'h48);
      peek(5'd0, v);
      chk("home_addr", 64'(v), 64'h48);

      // ---- back-to-back write while busy
      wr(1'b0, 8'h85);
      base = ovr_cnt;
      @(negedge clk); rs = 1'b1; rw = 1'b0; db_in = 8'h58; e = 1'b1;
      @(negedge clk); e = 1'b0;
      repeat (3) @(negedge clk);
      db_in = 8'h59; e = 1'b1;
      @(negedge clk); e = 1'b0;
      len = 0;
      while (busy && len < 200) begin len++; @(negedge clk); end
      repeat (3) @(negedge clk);
      chk("ovr_pulse", 64'(ovr_cnt - base), 64'd1);
      peek(5'd5, v); peek(5'd6, v2);
      chk("ovr_ddram", 64'({v, v2}), 64'h5865);
      wr(1'b1, 8'h5A);
      peek(5'd6, v);
      chk("ovr_addr", 64'(v), 64'h5A);

`ifdef LCD_READ_EN
      // ---- status and data reads
      wr(1'b0, 8'hC5);
      wr(1'b1, 8'h52);
      wr(1'b0, 8'hC5);
      do_rd(1'b0, v, oe);
      chk("stat_oe", 64'(oe), 64'd1);
      chk("stat_read", 64'(v), 64'h45);
      do_rd(1'b1, v, oe);
      chk("data_read", 64'(v), 64'h52);
      do_rd(1'b0, v, oe);
      chk("stat_after", 64'(v), 64'h46);
      chk("oe_idle", 64'(db_oe), 64'd0);
`else
      // ---- reads are ignored
      do_rd(1'b1, v, oe);
      chk("rd_oe_off", 64'(oe), 64'd0);
      chk("rd_dout_off", 64'(v), 64'd0);
      chk("rd_no_busy", 64'(busy), 64'd0);
`endif

      // ---- reset during a clear restarts the power-on clear
      @(negedge clk); rs = 1'b0; rw = 1'b0; db_in = 8'h01; e = 1'b1;
      @(negedge clk); e = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_flags", 64'({busy, display_on, cursor_on, blink_on}), 64'b1000);
      rst = 1'b1;
      por_len(len);
      chk("por_len_again", 64'(len), 64'd1640);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_char_responder.md
# lcd_char_responder

Synthesizable model of the responder end of the HD44780-style 8-bit character-LCD bus driven by the team's LCD sequencers. It decodes instruction and data writes framed by an E strobe, maintains a 2x16 DDRAM, cursor address and busy flag, and answers busy/address and data reads. The block sits on the demo board, or in simulation, in place of the physical display. It also exposes a side read port, so a bench or a display mirror can inspect the characters.

## Interface
- BUSY_CYCLES, 40: busy duration for ordinary instructions and data writes, in clk cycles (>=2).
- CLEAR_CYCLES, 1640: busy duration for clear and return-home (>=32).
- clk  in  1  clock; all inputs are synchronous to it.
- rst  in  1  reset, asynchronous, active-low.
- e  in  1  enable strobe; a transaction completes on its falling edge.
- rs  in  1  0 = instruction/status, 1 = data.
- rw  in  1  0 = write, 1 = read.
- db_in  in  8  bus write data.
- db_out  out  8  bus read data.
- db_oe  out  1  high while the responder drives the bus.
- busy  out  1  busy flag.
- display_on, cursor_on, blink_on  out  1 each  display-control state.
- rd_idx  in  5  side-port character index, {line, column[3:0]}.
- rd_char  out  8  DDRAM[rd_idx], registered, 1-cycle latency.
- overrun  out  1  one-cycle pulse when a write is dropped because busy=1.

## Operation
- Address register addr[6:0]. Valid ranges are 0x00-0x0F (line 0) and 0x40-0x4F (line 1). DDRAM index = {addr[6], addr[3:0]}.
- Instruction writes (rs=0, rw=0) decode by the highest set bit of db_in:
  - 0x01 clear: fill all 32 cells with 0x20, addr=0, incr=1; busy CLEAR_CYCLES.
  - 0x02/0x03 home: addr=0, DDRAM untouched; busy CLEAR_CYCLES.
  - 0x04-0x07 entry mode: incr=db[1]; db[0] (display shift) is ignored.
  - 0x08-0x0F display control: display_on=db[2], cursor_on=db[1], blink_on=db[0].
  - 0x10-0x1F shift: if db[3]=0, move the cursor right (db[2]=1) or left with wrap; display shift is ignored.
  - 0x20-0x3F function set: the eight_bit and two_line flags are stored only; the bus stays 8-bit.
  - 0x40-0x7F CGRAM address: cg_mode=1; later data writes are discarded with no address change.
  - 0x80-0xFF DDRAM address: addr={db[6],2'b00,db[3:0]} (bits 5:4 forced to 0); cg_mode=0.
- Data write (rs=1, rw=0, cg_mode=0): DDRAM[idx]=db_in, then step addr.
- Address step wraps: increment 0x0F->0x40, 0x4F->0x00; decrement 0x00->0x4F, 0x40->0x0F.
- Every accepted write sets busy for BUSY_CYCLES unless a longer duration is listed above.
- Write with busy=1: dropped, no state change, overrun pulses once.
- FSM states:
  - IDLE: waiting for a strobe.
  - EXEC: one cycle, applies the decoded write.
  - SWEEP: clear fill, one cell per cycle, 32 cycles.
  - WAIT: counts busy down.
- FSM transitions: IDLE->EXEC on an accepted falling edge. EXEC->SWEEP (clear) or EXEC->WAIT. SWEEP->WAIT after cell 31. WAIT->IDLE when the counter hits 0.
- Reset value of every output: db_out=0, db_oe=0, busy=1, display_on=0, cursor_on=0, blink_on=0, rd_char=0, overrun=0.
- Reset internal state: addr=0, incr=1, cg_mode=0. The FSM enters SWEEP (power-on clear), with total busy CLEAR_CYCLES.
- Reset asserted mid-sweep or mid-busy aborts the operation and restarts the power-on clear.

## Timing
- e is registered (e_q). A falling edge is detected when e_q=1 and e=0 at clock edge n.
- The write is applied and busy rises at edge n+1.
- busy falls exactly BUSY_CYCLES (or CLEAR_CYCLES) cycles after it rises. Sweep cycles count toward CLEAR_CYCLES.
- A falling edge detected on the same cycle busy falls counts as busy (dropped).
- Strobes are accepted starting the cycle after busy reads 0.
- rd_char is 1-cycle latency. During SWEEP it may return either old data or 0x20.

## Configuration
- LCD_READ_EN defined: reads are supported.
  - While e=1 and rw=1, db_oe=1 (registered, 1 cycle after e rises).
  - db_out = rs ? DDRAM[idx] : {busy, addr}.
  - A data read steps addr on the falling edge of e and does not set busy.
- LCD_READ_EN undefined: db_oe=0 and db_out=0 permanently; rw=1 strobes are ignored.

## Structure
- Package lcd_pkg:
  - opcode masks and constants: CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM.
  - FSM state enum.
  - LINE1_BASE=0x40, SPACE=0x20.
  - addr_step function (wrap rules).
- Sub-module lcd_ddram: 32x8 memory with one write port and two read ports (bus and side port).

## Test plan
- Power-on clear: release rst -> busy=1 for 1640 cycles; all rd_char=0x20.
- Init 0x38, 0x06, 0x0C, 0x01, 0x80, each waiting on busy low -> display_on=1, cursor_on=0, addr=0, DDRAM all 0x20.
- Write "Push Cen", then 0xC0, then "ter" -> idx 0-7 hold 50 75 73 68 20 43 65 6E; idx 16-18 hold 74 65 72.
- Write at 0x4F with incr=1 -> next write lands at 0x00. With incr=0 at 0x40 -> next write lands at 0x0F.
- Back-to-back write with no busy wait -> second write dropped, overrun=1 for 1 cycle, DDRAM unchanged.
- LCD_READ_EN: set addr 0x45, status read -> db_out=0x45 with busy bit 0. Data read -> DDRAM[21], addr becomes 0x46.
